// File: rtl/m_store_buffer_if.sv
// Bus bundle for the M-stage store buffer: store requests, load probe and the
// shared data-memory port. The master is the pipeline/DM side, the slave is the buffer.
interface m_store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          st_valid;
    logic [1:0]    st_type;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [31:0]   st_pc;
    logic          st_ready;

    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_hazard;

    logic [31:0]   dm_rdata;
    logic          dm_we;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic [31:0]   dm_pc;

    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_type, st_addr, st_data, st_pc,
        output ld_valid, ld_addr,
        output dm_rdata,
        input  st_ready, ld_hazard,
        input  dm_we, dm_addr, dm_wdata, dm_pc,
        input  empty, count
    );

    modport slave (
        input  st_valid, st_type, st_addr, st_data, st_pc,
        input  ld_valid, ld_addr,
        input  dm_rdata,
        output st_ready, ld_hazard,
        output dm_we, dm_addr, dm_wdata, dm_pc,
        output empty, count
    );
endinterface

// File: rtl/m_store_buffer.sv
// Posted store queue in front of the data memory: queues sw/sh/sb, drains one
// entry per cycle with a byte-lane read-modify-write, and flags loads that hit it.
module m_store_buffer #(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    m_store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [11:0]      idx_q  [DEPTH];
    logic [11:0]      idx_d  [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [3:0]       be_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];

    logic        full;
    logic        is_empty;
    logic        hit;
    logic        drain;
    logic        accept;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] merged;

    logic unused_st_addr;
    assign unused_st_addr = ^bus.st_addr[31:14];

    assign full     = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);
    assign accept   = bus.st_valid && !full;

    // Lane mask and replicated data; type 3 falls through to a full word store.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = bus.st_data;
        case (bus.st_type)
            2'd1: begin
                st_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.st_data[15:0]}};
            end
            2'd2: begin
                st_be    = 4'b0001 << bus.st_addr[1:0];
                st_wdata = {4{bus.st_data[7:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = bus.st_data;
            end
        endcase
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (idx_q[i] == bus.ld_addr[13:2])) begin
                hit = 1'b1;
            end
        end
        hit = hit && bus.ld_valid;
    end

    assign drain = !is_empty && (!bus.ld_valid || hit || full);

    always_comb begin
        merged = '0;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be_q[head_q][b] ? data_q[head_q][8*b +: 8]
                                               : bus.dm_rdata[8*b +: 8];
        end
    end

    assign bus.dm_we     = drain;
    assign bus.dm_addr   = drain ? {18'b0, idx_q[head_q], 2'b00} : bus.ld_addr;
    assign bus.dm_wdata  = drain ? merged : 32'b0;
    assign bus.dm_pc     = drain ? pc_q[head_q] : 32'b0;
    assign bus.ld_hazard = bus.ld_valid && (hit || full);
    assign bus.st_ready  = !full;
    assign bus.empty     = is_empty;
    assign bus.count     = count_q;

    // A drain and an accept never target the same slot: drain needs a non-empty
    // queue and accept a non-full one, so head==tail cannot hold for both.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        be_d    = be_q;
        data_d  = data_q;
        pc_d    = pc_q;

        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        if (accept) begin
            valid_d[tail_q] = 1'b1;
            idx_d[tail_q]   = bus.st_addr[13:2];
            be_d[tail_q]    = st_be;
            data_d[tail_q]  = st_wdata;
            pc_d[tail_q]    = bus.st_pc;
            tail_d          = tail_q + 1'b1;
        end

        case ({accept, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= '0;
                be_q[i]   <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end
endmodule
